// File: rtl/funct_seq_gen_pkg.sv
// rtl/funct_seq_gen_pkg.sv - opcode/funct constants and FSM state type for funct_seq_gen
package funct_seq_gen_pkg;

  localparam logic [5:0] OP_SPECIAL = 6'h00;
  localparam logic [5:0] OP_J       = 6'h02;
  localparam logic [5:0] OP_JAL     = 6'h03;
  localparam logic [5:0] OP_BEQ     = 6'h04;
  localparam logic [5:0] OP_BNE     = 6'h05;
  localparam logic [5:0] OP_ADDI    = 6'h08;
  localparam logic [5:0] OP_ADDIU   = 6'h09;
  localparam logic [5:0] OP_SLTI    = 6'h0A;
  localparam logic [5:0] OP_SLTIU   = 6'h0B;
  localparam logic [5:0] OP_ANDI    = 6'h0C;
  localparam logic [5:0] OP_ORI     = 6'h0D;
  localparam logic [5:0] OP_XORI    = 6'h0E;
  localparam logic [5:0] OP_LUI     = 6'h0F;
  localparam logic [5:0] OP_LB      = 6'h20;
  localparam logic [5:0] OP_LH      = 6'h21;
  localparam logic [5:0] OP_LW      = 6'h23;
  localparam logic [5:0] OP_LBU     = 6'h24;
  localparam logic [5:0] OP_LHU     = 6'h25;
  localparam logic [5:0] OP_SB      = 6'h28;
  localparam logic [5:0] OP_SH      = 6'h29;
  localparam logic [5:0] OP_SW      = 6'h2B;

  localparam logic [5:0] FUNCT_NOP   = 6'h00;
  localparam logic [5:0] FUNCT_SRL   = 6'h02;
  localparam logic [5:0] FUNCT_SRA   = 6'h03;
  localparam logic [5:0] FUNCT_SLLV  = 6'h04;
  localparam logic [5:0] FUNCT_SRLV  = 6'h06;
  localparam logic [5:0] FUNCT_SRAV  = 6'h07;
  localparam logic [5:0] FUNCT_JR    = 6'h08;
  localparam logic [5:0] FUNCT_JALR  = 6'h09;
  localparam logic [5:0] FUNCT_MFHI  = 6'h10;
  localparam logic [5:0] FUNCT_MTHI  = 6'h11;
  localparam logic [5:0] FUNCT_MFLO  = 6'h12;
  localparam logic [5:0] FUNCT_MTLO  = 6'h13;
  localparam logic [5:0] FUNCT_MULT  = 6'h18;
  localparam logic [5:0] FUNCT_MULTU = 6'h19;
  localparam logic [5:0] FUNCT_DIV   = 6'h1A;
  localparam logic [5:0] FUNCT_DIVU  = 6'h1B;
  localparam logic [5:0] FUNCT_ADD   = 6'h20;
  localparam logic [5:0] FUNCT_ADDU  = 6'h21;
  localparam logic [5:0] FUNCT_SUB   = 6'h22;
  localparam logic [5:0] FUNCT_SUBU  = 6'h23;
  localparam logic [5:0] FUNCT_AND   = 6'h24;
  localparam logic [5:0] FUNCT_OR    = 6'h25;
  localparam logic [5:0] FUNCT_XOR   = 6'h26;
  localparam logic [5:0] FUNCT_NOR   = 6'h27;
  localparam logic [5:0] FUNCT_SLT   = 6'h2A;
  localparam logic [5:0] FUNCT_SLTU  = 6'h2B;

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_FULL  = 2'd1,
    ST_MULTI = 2'd2
  } state_t;

  // SPECIAL funct codes that name a real instruction (mul/div handled separately)
  function automatic logic special_defined(input logic [5:0] f);
    return f inside {FUNCT_NOP, FUNCT_SRL, FUNCT_SRA, FUNCT_SLLV, FUNCT_SRLV, FUNCT_SRAV,
                     FUNCT_JR, FUNCT_JALR, FUNCT_MFHI, FUNCT_MTHI, FUNCT_MFLO, FUNCT_MTLO,
                     FUNCT_ADD, FUNCT_ADDU, FUNCT_SUB, FUNCT_SUBU, FUNCT_AND, FUNCT_OR,
                     FUNCT_XOR, FUNCT_NOR, FUNCT_SLT, FUNCT_SLTU};
  endfunction

endpackage

// File: rtl/funct_seq_gen_decode.sv
// rtl/funct_seq_gen_decode.sv - combinational {op, funct_in} to ALU funct map
module funct_decode
  import funct_seq_gen_pkg::*;
#(
  parameter int OP_W        = 6,
  parameter int FUNCT_W     = 6,
  parameter int EN_MULDIV   = 1,
  parameter int CHK_SPECIAL = 1
) (
  input  logic [OP_W-1:0]    op,
  input  logic [FUNCT_W-1:0] funct_in,
  output logic [FUNCT_W-1:0] funct,
  output logic               ri,
  output logic               is_mul,
  output logic               is_div
);

  logic fi_mul;
  logic fi_div;

  assign fi_mul = (funct_in == FUNCT_W'(FUNCT_MULT)) || (funct_in == FUNCT_W'(FUNCT_MULTU));
  assign fi_div = (funct_in == FUNCT_W'(FUNCT_DIV))  || (funct_in == FUNCT_W'(FUNCT_DIVU));

  always_comb begin
    funct  = FUNCT_W'(FUNCT_NOP);
    ri     = 1'b0;
    is_mul = 1'b0;
    is_div = 1'b0;
    case (op)
      OP_W'(OP_SPECIAL): begin
        if (fi_mul || fi_div) begin
          if (EN_MULDIV != 0) begin
            funct  = funct_in;
            is_mul = fi_mul;
            is_div = fi_div;
          end else begin
            ri = 1'b1;
          end
        end else if ((CHK_SPECIAL != 0) && !special_defined(6'(funct_in))) begin
          ri = 1'b1;
        end else begin
          funct = funct_in;
        end
      end
      OP_W'(OP_ORI), OP_W'(OP_LUI), OP_W'(OP_JAL):
        funct = FUNCT_W'(FUNCT_OR);
      OP_W'(OP_LB), OP_W'(OP_LBU), OP_W'(OP_LH), OP_W'(OP_LHU), OP_W'(OP_LW),
      OP_W'(OP_SB), OP_W'(OP_SH), OP_W'(OP_SW), OP_W'(OP_ADDIU):
        funct = FUNCT_W'(FUNCT_ADDU);
      OP_W'(OP_ADDI):  funct = FUNCT_W'(FUNCT_ADD);
      OP_W'(OP_ANDI):  funct = FUNCT_W'(FUNCT_AND);
      OP_W'(OP_XORI):  funct = FUNCT_W'(FUNCT_XOR);
      OP_W'(OP_SLTI):  funct = FUNCT_W'(FUNCT_SLT);
      OP_W'(OP_SLTIU): funct = FUNCT_W'(FUNCT_SLTU);
      OP_W'(OP_J), OP_W'(OP_BEQ), OP_W'(OP_BNE): ri = 1'b0;
      default: ri = 1'b1;
    endcase
  end

endmodule

// File: rtl/funct_seq_gen.sv
// rtl/funct_seq_gen.sv - registered ALU funct generator with mul/div busy sequencing
module funct_seq_gen
  import funct_seq_gen_pkg::*;
#(
  parameter int OP_W        = 6,
  parameter int FUNCT_W     = 6,
  parameter int EN_MULDIV   = 1,
  parameter int MUL_CYCLES  = 4,
  parameter int DIV_CYCLES  = 33,
  parameter int CHK_SPECIAL = 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               flush,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [OP_W-1:0]    op,
  input  logic [FUNCT_W-1:0] funct_in,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [FUNCT_W-1:0] funct,
  output logic               ri,
  output logic               busy
);

  localparam int LAT_MAX = (MUL_CYCLES > DIV_CYCLES) ? MUL_CYCLES : DIV_CYCLES;
  localparam int CNT_W   = (LAT_MAX > 1) ? $clog2(LAT_MAX) : 1;
  localparam logic [CNT_W-1:0] MUL_LOAD = CNT_W'(MUL_CYCLES - 1);
  localparam logic [CNT_W-1:0] DIV_LOAD = CNT_W'(DIV_CYCLES - 1);

  state_t             state;
  logic [CNT_W-1:0]   cnt;
  logic [FUNCT_W-1:0] dec_funct;
  logic               dec_ri;
  logic               dec_is_mul;
  logic               dec_is_div;
  logic               fire;

  funct_decode #(
    .OP_W       (OP_W),
    .FUNCT_W    (FUNCT_W),
    .EN_MULDIV  (EN_MULDIV),
    .CHK_SPECIAL(CHK_SPECIAL)
  ) u_decode (
    .op      (op),
    .funct_in(funct_in),
    .funct   (dec_funct),
    .ri      (dec_ri),
    .is_mul  (dec_is_mul),
    .is_div  (dec_is_div)
  );

  assign in_ready = !flush && ((state == ST_EMPTY) || ((state == ST_FULL) && out_ready));
  assign fire     = in_valid && in_ready;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= ST_EMPTY;
      funct     <= FUNCT_W'(FUNCT_NOP);
      ri        <= 1'b0;
      out_valid <= 1'b0;
      busy      <= 1'b0;
      cnt       <= '0;
    end else if (flush) begin
      state     <= ST_EMPTY;
      funct     <= FUNCT_W'(FUNCT_NOP);
      ri        <= 1'b0;
      out_valid <= 1'b0;
      busy      <= 1'b0;
      cnt       <= '0;
    end else begin
      case (state)
        ST_EMPTY, ST_FULL: begin
          if (fire) begin
            funct <= dec_funct;
            ri    <= dec_ri;
            if (dec_is_mul || dec_is_div) begin
              state     <= ST_MULTI;
              out_valid <= 1'b0;
              busy      <= 1'b1;
              cnt       <= dec_is_mul ? MUL_LOAD : DIV_LOAD;
            end else begin
              state     <= ST_FULL;
              out_valid <= 1'b1;
            end
          end else if ((state == ST_FULL) && out_ready) begin
            state     <= ST_EMPTY;
            out_valid <= 1'b0;
          end
        end
        ST_MULTI: begin
          // cnt reaching zero marks the last busy cycle; funct is already loaded
          if (cnt == '0) begin
            state     <= ST_FULL;
            out_valid <= 1'b1;
            busy      <= 1'b0;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        default: begin
          state     <= ST_EMPTY;
          out_valid <= 1'b0;
          busy      <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_funct_seq_gen.sv
// tb/tb_funct_seq_gen.sv - scoreboard bench for funct_seq_gen
module tb_funct_seq_gen;

  localparam int MUL_LAT = 4;
  localparam int DIV_LAT = 33;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       flush = 1'b0;
  logic       in_valid = 1'b0;
  logic       out_ready = 1'b0;
  logic [5:0] op = '0;
  logic [5:0] funct_in = '0;
  logic       in_ready, out_valid, ri, busy;
  logic [5:0] funct;

  logic       in_valid2 = 1'b0;
  logic [5:0] op2 = '0;
  logic [5:0] funct_in2 = '0;
  logic       flush2 = 1'b0;
  logic       out_ready2 = 1'b1;
  logic       in_ready2, out_valid2, ri2, busy2;
  logic [5:0] funct2;

  int n_checks = 0;
  int n_pass = 0;

  typedef struct packed {
    logic [5:0] f;
    logic       r;
  } exp_t;
  exp_t sb[$];

  bit         m_full = 1'b0;
  int         m_left = 0;
  logic [5:0] m_funct = '0;
  bit         m_ri = 1'b0;

  logic [5:0] ops_tab [0:20] = '{6'h00, 6'h02, 6'h03, 6'h04, 6'h05, 6'h08, 6'h09,
                                 6'h0A, 6'h0B, 6'h0C, 6'h0D, 6'h0E, 6'h0F, 6'h20,
                                 6'h21, 6'h23, 6'h24, 6'h25, 6'h28, 6'h29, 6'h2B};
  logic [5:0] alu_tab [0:11] = '{6'h00, 6'h02, 6'h08, 6'h10, 6'h20, 6'h21,
                                 6'h22, 6'h24, 6'h25, 6'h27, 6'h2A, 6'h2B};
  logic [5:0] md_tab  [0:3]  = '{6'h18, 6'h19, 6'h1A, 6'h1B};

  funct_seq_gen #(
    .OP_W(6), .FUNCT_W(6), .EN_MULDIV(1), .MUL_CYCLES(MUL_LAT),
    .DIV_CYCLES(DIV_LAT), .CHK_SPECIAL(1)
  ) dut (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
    .op(op), .funct_in(funct_in), .out_valid(out_valid), .out_ready(out_ready),
    .funct(funct), .ri(ri), .busy(busy)
  );

  funct_seq_gen #(
    .OP_W(6), .FUNCT_W(6), .EN_MULDIV(0), .MUL_CYCLES(MUL_LAT),
    .DIV_CYCLES(DIV_LAT), .CHK_SPECIAL(0)
  ) dut2 (
    .clk(clk), .rst(rst), .flush(flush2), .in_valid(in_valid2), .in_ready(in_ready2),
    .op(op2), .funct_in(funct_in2), .out_valid(out_valid2), .out_ready(out_ready2),
    .funct(funct2), .ri(ri2), .busy(busy2)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
  endtask

  // Reference decode written from the instruction table; lat=0 means single-cycle
  task automatic ref_decode(input logic [5:0] o, input logic [5:0] fi, input bit en_md,
                            input bit chk_sp, output logic [5:0] f, output bit r,
                            output int lat);
    f = 6'h00; r = 1'b0; lat = 0;
    case (o)
      6'h00: begin
        if (fi inside {6'h18, 6'h19, 6'h1A, 6'h1B}) begin
          if (en_md) begin
            f = fi;
            lat = (fi inside {6'h18, 6'h19}) ? MUL_LAT : DIV_LAT;
          end else r = 1'b1;
        end else if (chk_sp && !(fi inside {6'h00, 6'h02, 6'h03, 6'h04, 6'h06, 6'h07,
                     6'h08, 6'h09, 6'h10, 6'h11, 6'h12, 6'h13, [6'h20:6'h27], 6'h2A, 6'h2B}))
          r = 1'b1;
        else f = fi;
      end
      6'h0D, 6'h0F, 6'h03: f = 6'h25;
      6'h20, 6'h24, 6'h21, 6'h25, 6'h23, 6'h28, 6'h29, 6'h2B, 6'h09: f = 6'h21;
      6'h08: f = 6'h20;
      6'h0C: f = 6'h24;
      6'h0E: f = 6'h26;
      6'h0A: f = 6'h2A;
      6'h0B: f = 6'h2B;
      6'h02, 6'h04, 6'h05: r = 1'b0;
      default: r = 1'b1;
    endcase
  endtask

  // Reference model: one held entry plus a remaining-busy-cycle count
  initial forever begin
    logic [5:0] f;
    bit r;
    int lat;
    bit rdy;
    @(posedge clk);
    if (!rst) begin
      m_full = 1'b0; m_left = 0; m_funct = 6'h00; m_ri = 1'b0;
      sb.delete();
    end else begin
      rdy = !flush && ((!m_full && m_left == 0) || (m_full && out_ready));
      if (flush) begin
        m_full = 1'b0; m_left = 0; m_funct = 6'h00; m_ri = 1'b0;
      end else begin
        if (m_left > 0) begin
          m_left--;
          if (m_left == 0) m_full = 1'b1;
        end else if (m_full && out_ready) m_full = 1'b0;
        if (in_valid && rdy) begin
          ref_decode(op, funct_in, 1'b1, 1'b1, f, r, lat);
          m_funct = f; m_ri = r;
          if (lat > 0) begin m_left = lat; m_full = 1'b0; end
          else m_full = 1'b1;
          sb.push_back('{f: f, r: r});
        end
      end
    end
  end

  // Monitor: compares presented outputs against the model and scoreboard
  initial forever begin
    bit exp_rdy;
    @(negedge clk);
    if (rst) begin
      exp_rdy = !flush && ((!m_full && m_left == 0) || (m_full && out_ready));
      chk("out_valid", int'(out_valid), int'(m_full));
      chk("busy", int'(busy), int'(m_left != 0));
      chk("in_ready", int'(in_ready), int'(exp_rdy));
      chk("funct_reg", int'(funct), int'(m_funct));
      chk("ri_reg", int'(ri), int'(m_ri));
      if (out_valid) begin
        chk("sb_nonempty", int'(sb.size() != 0), 1);
        if (sb.size() != 0) begin
          chk("sb_funct", int'(funct), int'(sb[0].f));
          chk("sb_ri", int'(ri), int'(sb[0].r));
          if (out_ready || flush) void'(sb.pop_front());
        end
      end
      if (flush) sb.delete();
    end
  end

  task automatic drive_cycle(input bit v, input logic [5:0] o, input logic [5:0] fi,
                             input bit rdy, input bit fl);
    in_valid = v; op = o; funct_in = fi; out_ready = rdy; flush = fl;
    @(posedge clk);
    #1;
  endtask

  function automatic logic [5:0] pick_op();
    int r = $urandom_range(0, 99);
    if (r < 20) return 6'h00;
    if (r < 30) return 6'($urandom);
    return ops_tab[$urandom_range(0, 20)];
  endfunction

  function automatic logic [5:0] pick_funct();
    int r = $urandom_range(0, 99);
    if (r < 20) return md_tab[$urandom_range(0, 3)];
    if (r < 35) return 6'($urandom);
    return alu_tab[$urandom_range(0, 11)];
  endfunction

  initial begin
    #1 rst = 1'b0;
    #1;
    chk("rst_funct", int'(funct), 0);
    chk("rst_out_valid", int'(out_valid), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_ri", int'(ri), 0);
    repeat (2) @(posedge clk);
    #2 rst = 1'b1;
    @(posedge clk);
    #1;

    // Back-to-back single-cycle ops
    drive_cycle(1, 6'h0D, 6'h00, 1, 0);
    chk("b2b_ori", int'(funct), 'h25);
    drive_cycle(1, 6'h23, 6'h00, 1, 0);
    chk("b2b_lw", int'(funct), 'h21);
    chk("b2b_valid", int'(out_valid), 1);
    drive_cycle(1, 6'h0A, 6'h00, 1, 0);
    chk("b2b_slti", int'(funct), 'h2A);
    chk("b2b_valid2", int'(out_valid), 1);
    drive_cycle(0, 6'h00, 6'h00, 1, 0);

    // Backpressure
    drive_cycle(1, 6'h0C, 6'h00, 1, 0);
    for (int i = 0; i < 3; i++) begin
      drive_cycle(1, 6'h0D, 6'h00, 0, 0);
      chk("bp_hold_funct", int'(funct), 'h24);
      chk("bp_in_ready", int'(in_ready), 0);
    end
    drive_cycle(1, 6'h0D, 6'h00, 1, 0);
    chk("bp_release", int'(funct), 'h25);
    drive_cycle(0, 6'h00, 6'h00, 1, 0);

    // MULT busy window
    drive_cycle(1, 6'h00, 6'h18, 1, 0);
    for (int i = 0; i < MUL_LAT; i++) begin
      chk("mult_busy", int'(busy), 1);
      chk("mult_no_valid", int'(out_valid), 0);
      chk("mult_in_ready", int'(in_ready), 0);
      drive_cycle(0, 6'h00, 6'h00, 0, 0);
    end
    chk("mult_valid", int'(out_valid), 1);
    chk("mult_funct", int'(funct), 'h18);
    chk("mult_busy_done", int'(busy), 0);
    drive_cycle(0, 6'h00, 6'h00, 1, 0);

    // Flush during DIV
    drive_cycle(1, 6'h00, 6'h1A, 1, 0);
    drive_cycle(0, 6'h00, 6'h00, 1, 0);
    drive_cycle(1, 6'h0D, 6'h00, 1, 1);
    chk("flush_busy", int'(busy), 0);
    chk("flush_valid", int'(out_valid), 0);
    chk("flush_funct", int'(funct), 0);
    drive_cycle(0, 6'h00, 6'h00, 1, 0);

    // Reserved encodings
    drive_cycle(1, 6'h3F, 6'h00, 1, 0);
    chk("ri_op3f", int'(ri), 1);
    chk("ri_op3f_funct", int'(funct), 0);
    drive_cycle(1, 6'h00, 6'h3F, 1, 0);
    chk("ri_special3f", int'(ri), 1);
    drive_cycle(0, 6'h00, 6'h00, 1, 0);

    // Reset mid-MULTI
    drive_cycle(1, 6'h00, 6'h19, 1, 0);
    drive_cycle(0, 6'h00, 6'h00, 1, 0);
    #2 rst = 1'b0;
    #1;
    chk("rstmid_funct", int'(funct), 0);
    chk("rstmid_valid", int'(out_valid), 0);
    chk("rstmid_busy", int'(busy), 0);
    @(posedge clk);
    #2 rst = 1'b1;
    chk("rstrel_in_ready", int'(in_ready), 1);
    @(posedge clk);
    #1;

    for (int i = 0; i < 3000; i++)
      drive_cycle($urandom_range(0, 99) < 70, pick_op(), pick_funct(),
                  $urandom_range(0, 99) < 75, $urandom_range(0, 99) < 4);
    repeat (40) drive_cycle(0, 6'h00, 6'h00, 1, 0);
    chk("sb_drained", sb.size(), 0);

    // EN_MULDIV=0, CHK_SPECIAL=0 instance
    in_valid2 = 1'b1; op2 = 6'h00; funct_in2 = 6'h1B;
    @(posedge clk); #1;
    chk("nomd_divu_ri", int'(ri2), 1);
    chk("nomd_divu_funct", int'(funct2), 0);
    chk("nomd_divu_valid", int'(out_valid2), 1);
    chk("nomd_divu_busy", int'(busy2), 0);
    funct_in2 = 6'h3F;
    @(posedge clk); #1;
    chk("nochk_funct", int'(funct2), 'h3F);
    chk("nochk_ri", int'(ri2), 0);
    op2 = 6'h0E;
    @(posedge clk); #1;
    chk("nochk_xori", int'(funct2), 'h26);
    in_valid2 = 1'b0;

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
